// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one external combinational ALU among N_REQ requesters.
// Optional macro ALU_ARB_OPCHECK_EN rejects opcodes 4'b1011..4'b1111 with rsp_err instead of executing them.
module alu_arbiter #(
  parameter int N_REQ       = 2,
  parameter int EXEC_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [4*N_REQ-1:0]  req_op,
  input  logic [32*N_REQ-1:0] req_a,
  input  logic [32*N_REQ-1:0] req_b,
  output logic [N_REQ-1:0]    rsp_valid,
  input  logic [N_REQ-1:0]    rsp_ready,
  output logic [31:0]         rsp_data,
  output logic                rsp_err,
  output logic [3:0]          alu_op,
  output logic [31:0]         alu_op1,
  output logic [31:0]         alu_op2,
  input  logic [31:0]         alu_result,
  output logic [1:0]          dbg_state
);
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EXEC_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e           state_q;
  logic [IDX_W-1:0] rr_ptr_q;
  logic [IDX_W-1:0] gnt_id_q;
  logic [CNT_W-1:0] exec_cnt_q;
  logic [N_REQ-1:0] rsp_valid_q;
  logic [31:0]      rsp_data_q;
  logic             rsp_err_q;
  logic [3:0]       alu_op_q;
  logic [31:0]      alu_op1_q;
  logic [31:0]      alu_op2_q;

  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic [N_REQ-1:0] win_oh;
  logic [N_REQ-1:0] gnt_oh;
  logic [3:0]       sel_op;
  logic [31:0]      sel_a;
  logic [31:0]      sel_b;
  int               cand;
  logic [IDX_W-1:0] cand_idx;

  // Round-robin scan starting just after the last winner; first valid index wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      cand_idx = IDX_W'(cand);
      if (!win_found && req_valid[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    win_oh = '0;
    if (win_found) win_oh[win_idx] = 1'b1;
    gnt_oh = '0;
    gnt_oh[gnt_id_q] = 1'b1;
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_idx == IDX_W'(i)) begin
        sel_op = req_op[4*i +: 4];
        sel_a  = req_a[32*i +: 32];
        sel_b  = req_b[32*i +: 32];
      end
    end
  end

  // Request side: a transfer happens in a cycle where req_valid[i] & req_ready[i]; req_ready is only
  // ever raised in IDLE, for the single round-robin winner. Response side: rsp_valid[gnt] holds with
  // stable data until rsp_ready[gnt] is seen high on a rising edge.
  assign req_ready = (state_q == S_IDLE) ? win_oh : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= IDX_W'(N_REQ - 1);
      gnt_id_q    <= '0;
      exec_cnt_q  <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      alu_op_q    <= '0;
      alu_op1_q   <= '0;
      alu_op2_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (win_found) begin
            gnt_id_q <= win_idx;
            rr_ptr_q <= win_idx;
`ifdef ALU_ARB_OPCHECK_EN
            if (sel_op >= 4'b1011) begin
              rsp_data_q  <= '0;
              rsp_err_q   <= 1'b1;
              rsp_valid_q <= win_oh;
              state_q     <= S_RESP;
            end else begin
              alu_op_q   <= sel_op;
              alu_op1_q  <= sel_a;
              alu_op2_q  <= sel_b;
              exec_cnt_q <= '0;
              state_q    <= S_EXEC;
            end
`else
            alu_op_q   <= sel_op;
            alu_op1_q  <= sel_a;
            alu_op2_q  <= sel_b;
            exec_cnt_q <= '0;
            state_q    <= S_EXEC;
`endif
          end
        end
        S_EXEC: begin
          exec_cnt_q <= exec_cnt_q + CNT_W'(1);
          if (exec_cnt_q == CNT_LAST) begin
            rsp_data_q  <= alu_result;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= gnt_oh;
            state_q     <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready[gnt_id_q]) begin
            rsp_valid_q <= '0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign alu_op    = alu_op_q;
  assign alu_op1   = alu_op1_q;
  assign alu_op2   = alu_op2_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed scoreboard bench for alu_arbiter with a behavioural ALU on the alu_* port.
// Expectations follow ALU_ARB_OPCHECK_EN when the macro is defined for the build.
module tb_alu_arbiter;
  localparam int N  = 3;
  localparam int EX = 3;
  localparam int EW = N + 33;

  logic            clk = 1'b0;
  logic            rstn;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [4*N-1:0]  req_op;
  logic [32*N-1:0] req_a;
  logic [32*N-1:0] req_b;
  logic [N-1:0]    rsp_valid;
  logic [N-1:0]    rsp_ready;
  logic [31:0]     rsp_data;
  logic            rsp_err;
  logic [3:0]      alu_op;
  logic [31:0]     alu_op1;
  logic [31:0]     alu_op2;
  logic [31:0]     alu_result;
  logic [1:0]      dbg_state;

  logic [EW-1:0] exp_q[$];
  int            lat_q[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            hs_cyc = 0;
  logic [3:0]    last_op = 4'd0;
  logic [N-1:0]  prev_v = '0;
  logic [EW-1:0] e;

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      4'b0000: return a << b[4:0];
      4'b0001: return a >> b[4:0];
      4'b0010: return 32'($signed(a) >>> b[4:0]);
      4'b0011: return a + b;
      4'b0100: return a - b;
      4'b0101: return a & b;
      4'b0110: return a | b;
      4'b0111: return a ^ b;
      4'b1000: return {31'd0, $signed(a) < $signed(b)};
      4'b1001: return {31'd0, a == b};
      4'b1010: return {31'd0, a != b};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  assign alu_result = ref_alu(alu_op, alu_op1, alu_op2);

  alu_arbiter #(.N_REQ(N), .EXEC_CYCLES(EX)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .alu_op(alu_op), .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_result(alu_result), .dbg_state(dbg_state)
  );

  // Clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: latency checked when rsp_valid rises, payload checked at the response handshake.
  always @(negedge clk) begin
    if (rstn) begin
      if (rsp_valid != '0 && prev_v == '0) begin
        if (lat_q.size() == 0) check("unexpected_rsp", 64'(rsp_valid), 64'd0);
        else check("latency", 64'(cyc - hs_cyc), 64'(lat_q.pop_front()));
      end
      if ((rsp_valid & rsp_ready) != '0) begin
        if (exp_q.size() == 0) check("unexpected_rsp_hs", 64'(rsp_valid), 64'd0);
        else begin
          e = exp_q.pop_front();
          check("rsp", 64'({rsp_valid, rsp_err, rsp_data}), 64'(e));
        end
      end
      prev_v = rsp_valid;
    end else begin
      prev_v = '0;
    end
  end

  // Driver tasks
  task automatic set_req(input int id, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b);
    req_op[4*id +: 4]  = op;
    req_a[32*id +: 32] = a;
    req_b[32*id +: 32] = b;
    req_valid[id]      = 1'b1;
  endtask

  task automatic wait_grant(input int id);
    logic [N-1:0] oh;
    logic [3:0]   op;
    logic [31:0]  a;
    logic [31:0]  b;
    bit           seen;
    oh = '0;
    oh[id] = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      seen = (req_ready != '0);
    end
    check("grant", 64'(req_ready), 64'(oh));
    if (seen) begin
      op = req_op[4*id +: 4];
      a  = req_a[32*id +: 32];
      b  = req_b[32*id +: 32];
      hs_cyc = cyc;
`ifdef ALU_ARB_OPCHECK_EN
      if (op >= 4'b1011) begin
        exp_q.push_back({oh, 1'b1, 32'h0});
        lat_q.push_back(1);
      end else begin
        exp_q.push_back({oh, 1'b0, ref_alu(op, a, b)});
        lat_q.push_back(EX + 1);
        last_op = op;
      end
`else
      exp_q.push_back({oh, 1'b0, ref_alu(op, a, b)});
      lat_q.push_back(EX + 1);
      last_op = op;
`endif
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && exp_q.size() != 0; k++) @(negedge clk);
    check("drain", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev;
    int nxt;
    logic [31:0] stall_exp;
    rstn = 1'b0;
    req_valid = '0;
    req_op = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_data", 64'(rsp_data), 64'd0);
    check("rst_rsp_err", 64'(rsp_err), 64'd0);
    check("rst_alu_op", 64'(alu_op), 64'd0);
    check("rst_alu_op1", 64'(alu_op1), 64'd0);
    check("rst_alu_op2", 64'(alu_op2), 64'd0);
    rstn = 1'b1;
    rsp_ready = '1;
    @(posedge clk);
    #1;

    // Step 1: all valid after reset -> index 0 wins; add 0x101+1
    set_req(0, 4'b0011, 32'h101, 32'h1);
    set_req(1, 4'b0110, 32'h5, 32'h6);
    set_req(2, 4'b0111, 32'h7, 32'h8);
    wait_grant(0);
    req_valid = '0;
    drain();

    // Step 2: requester 1 alone, arithmetic shift then signed compare
    set_req(1, 4'b0010, 32'h8001_0100, 32'h1);
    wait_grant(1);
    set_req(1, 4'b1000, 32'h101, 32'h8100_0001);
    wait_grant(1);
    req_valid = '0;
    drain();

    // Step 3: all requesters continuously valid -> strict rotation 2,0,1,2,0,1
    set_req(0, 4'b0100, 32'h101, 32'h1);
    set_req(1, 4'b1001, 32'h101, 32'h101);
    set_req(2, 4'b0001, 32'h8000_0000, 32'd4);
    prev = 1;
    for (int g = 0; g < 6; g++) begin
      nxt = (prev + 1) % N;
      wait_grant(nxt);
      set_req(nxt, 4'($urandom_range(0, 10)), $urandom, $urandom);
      prev = nxt;
    end
    req_valid = '0;
    drain();

    // Step 4: response back-pressure for 10 cycles; other rsp_ready bits must be ignored
    rsp_ready = '0;
    set_req(0, 4'b0111, 32'hF0F0_1234, 32'h0FF0_4321);
    wait_grant(0);
    req_valid = '0;
    stall_exp = ref_alu(4'b0111, 32'hF0F0_1234, 32'h0FF0_4321);
    set_req(2, 4'b0101, 32'hFFFF_0000, 32'h1234_5678);
    rsp_ready = 3'b110;
    for (int k = 0; k < 40 && rsp_valid == '0; k++) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      check("stall_valid", 64'(rsp_valid), 64'(3'b001));
      check("stall_data", 64'(rsp_data), 64'(stall_exp));
      check("stall_ready", 64'(req_ready), 64'd0);
      check("stall_alu_op", 64'(alu_op), 64'(4'b0111));
      if (k == 3) req_valid[1] = 1'b1;
      if (k == 6) req_valid[1] = 1'b0;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    rsp_ready = '1;
    wait_grant(2);
    req_valid = '0;
    drain();

    // Step 5: reset while an op is executing
    set_req(1, 4'b0011, 32'hAAAA_0001, 32'h1);
    wait_grant(1);
    req_valid = '0;
    @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("mid_rst_rsp_data", 64'(rsp_data), 64'd0);
    check("mid_rst_alu_op", 64'(alu_op), 64'd0);
    check("mid_rst_alu_op1", 64'(alu_op1), 64'd0);
    check("mid_rst_alu_op2", 64'(alu_op2), 64'd0);
    check("mid_rst_req_ready", 64'(req_ready), 64'd0);
    exp_q.delete();
    lat_q.delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (10) @(negedge clk);
    check("post_rst_quiet", 64'(rsp_valid), 64'd0);
    @(posedge clk);
    #1;
    set_req(0, 4'b0000, 32'h0000_0F0F, 32'd8);
    set_req(1, 4'b0011, 32'hFFFF_FFFF, 32'h2);
    set_req(2, 4'b0100, 32'h0, 32'h1);
    wait_grant(0);
    req_valid = '0;
    drain();

    // Step 6: undefined opcodes at the boundary, plus the last defined one
    set_req(2, 4'b1111, 32'h1234, 32'h5678);
    wait_grant(2);
    req_valid = '0;
    @(negedge clk);
    check("undef_alu_op", 64'(alu_op), 64'(last_op));
    drain();
    set_req(0, 4'b1011, 32'h9, 32'h9);
    wait_grant(0);
    req_valid = '0;
    drain();
    set_req(1, 4'b1010, 32'h9, 32'h9);
    wait_grant(1);
    req_valid = '0;
    drain();

    check("sb_lat_empty", 64'(lat_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
